// File: rtl/prime_scan_ctrl.sv
// Sweeps an operand range through an external combinational prime checker and
// collects a bitmap, a count and the largest prime, returned over valid/ready.
module prime_scan_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MASK_W = 2 ** WIDTH,
    parameter int unsigned CNT_W  = WIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    output logic              busy,
    output logic [WIDTH-1:0]  chk_a,
    input  logic              chk_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [MASK_W-1:0] prime_mask,
    output logic [CNT_W-1:0]  prime_cnt,
    output logic [WIDTH-1:0]  last_prime,
    output logic              found,
    output logic              range_err
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            chk_a      <= '0;
            prime_mask <= '0;
            prime_cnt  <= '0;
            last_prime <= '0;
            found      <= 1'b0;
            range_err  <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        hi_q       <= hi;
                        prime_mask <= '0;
                        prime_cnt  <= '0;
                        last_prime <= '0;
                        found      <= 1'b0;
                        busy       <= 1'b1;
                        if (lo <= hi) begin
                            chk_a     <= lo;
                            range_err <= 1'b0;
                            state_q   <= StScan;
                        end else begin
                            // Inverted range: skip the sweep, report an empty result.
                            range_err <= 1'b1;
                            res_valid <= 1'b1;
                            state_q   <= StHold;
                        end
                    end
                end
                StScan: begin
                    if (chk_y) begin
                        prime_mask[chk_a] <= 1'b1;
                        prime_cnt         <= prime_cnt + CNT_W'(1);
                        last_prime        <= chk_a;
                        found             <= 1'b1;
                    end
                    // Compare before increment so hi = max never wraps chk_a.
                    if (chk_a == hi_q) begin
                        res_valid <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        chk_a <= chk_a + WIDTH'(1);
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed bench for prime_scan_ctrl with a behavioural 4-bit prime checker.
module tb_prime_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic        busy;
    logic [3:0]  chk_a;
    logic        chk_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] prime_mask;
    logic [4:0]  prime_cnt;
    logic [3:0]  last_prime;
    logic        found;
    logic        range_err;

    int n_chk;
    int n_fail;

    logic [15:0] prime_tbl;

    prime_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lo         (lo),
        .hi         (hi),
        .busy       (busy),
        .chk_a      (chk_a),
        .chk_y      (chk_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .prime_mask (prime_mask),
        .prime_cnt  (prime_cnt),
        .last_prime (last_prime),
        .found      (found),
        .range_err  (range_err)
    );

    // Primes below 16: 2, 3, 5, 7, 11, 13.
    assign chk_y = prime_tbl[chk_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a start and count cycles until res_valid (bounded).
    task automatic do_scan(input logic [3:0] l, input logic [3:0] h, output int cyc);
        start = 1'b1;
        lo    = l;
        hi    = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        lo    = ~l;
        hi    = ~h;
        cyc   = 0;
        while (!res_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({busy, res_valid, found, range_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, res_valid, found, range_err});
        end
        n_chk++;
        if ({chk_a, prime_mask, prime_cnt, last_prime} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {chk_a, prime_mask, prime_cnt, last_prime});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_range();
        int cyc;
        res_ready = 1'b1;
        do_scan(4'd0, 4'd15, cyc);
        n_chk++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL full_cycles: got %0d expected 16", cyc);
        end
        n_chk++;
        if (prime_mask !== 16'h28AC) begin
            n_fail++;
            $display("FAIL full_mask: got %h expected 28ac", prime_mask);
        end
        n_chk++;
        if (prime_cnt !== 5'd6 || last_prime !== 4'd13) begin
            n_fail++;
            $display("FAIL full_cnt_last: got %0d/%0d expected 6/13", prime_cnt, last_prime);
        end
        n_chk++;
        if (found !== 1'b1 || range_err !== 1'b0 || chk_a !== 4'd15) begin
            n_fail++;
            $display("FAIL full_flags: got found=%b err=%b chk_a=%0d expected 1 0 15",
                     found, range_err, chk_a);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        n_chk++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || prime_cnt !== 5'd6) begin
            n_fail++;
            $display("FAIL full_return: got valid=%b busy=%b cnt=%0d expected 0 0 6",
                     res_valid, busy, prime_cnt);
        end
    endtask

    task automatic test_mid_range();
        int cyc;
        do_scan(4'd11, 4'd13, cyc);
        n_chk++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL mid_cycles: got %0d expected 3", cyc);
        end
        n_chk++;
        if (prime_mask !== 16'h2800 || prime_cnt !== 5'd2 || last_prime !== 4'd13) begin
            n_fail++;
            $display("FAIL mid_result: got %h/%0d/%0d expected 2800/2/13",
                     prime_mask, prime_cnt, last_prime);
        end
        handshake();
    endtask

    task automatic test_single_nonprime();
        int cyc;
        do_scan(4'd4, 4'd4, cyc);
        n_chk++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL single_cycles: got %0d expected 1", cyc);
        end
        n_chk++;
        if (prime_mask !== 16'h0 || prime_cnt !== 5'd0 || last_prime !== 4'd0 || found !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got %h/%0d/%0d/%b expected 0/0/0/0",
                     prime_mask, prime_cnt, last_prime, found);
        end
        handshake();
    endtask

    task automatic test_range_err();
        int cyc;
        do_scan(4'd9, 4'd3, cyc);
        n_chk++;
        if (cyc !== 0) begin
            n_fail++;
            $display("FAIL err_latency: got %0d extra cycles expected 0", cyc);
        end
        n_chk++;
        if (range_err !== 1'b1 || prime_cnt !== 5'd0 || chk_a !== 4'd4) begin
            n_fail++;
            $display("FAIL err_result: got err=%b cnt=%0d chk_a=%0d expected 1 0 4",
                     range_err, prime_cnt, chk_a);
        end
        handshake();
        n_chk++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_release: got valid=%b expected 0", res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start = 1'b1;
        lo    = 4'd12;
        hi    = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Second scan cycle: a start request must be ignored.
        @(posedge clk);
        #1;
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd15;
        cyc   = 1;
        while (!res_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_chk++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d expected 4", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (res_valid !== 1'b1 || prime_mask !== 16'h2000 || prime_cnt !== 5'd1
                || last_prime !== 4'd13) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: got v=%b %h/%0d/%0d expected 1 2000/1/13",
                         i, res_valid, prime_mask, prime_cnt, last_prime);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start     = 1'b0;
        n_chk++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || prime_mask !== 16'h2000) begin
            n_fail++;
            $display("FAIL b2b_return: got v=%b busy=%b mask=%h expected 0 0 2000",
                     res_valid, busy, prime_mask);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_ignored: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int seen;
        start = 1'b1;
        lo    = 4'd0;
        hi    = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if (chk_a !== 4'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got chk_a=%0d busy=%b expected 2 1", chk_a, busy);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, res_valid, found, range_err, chk_a, prime_mask, prime_cnt, last_prime} !== 33'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got %h expected 0",
                     {busy, res_valid, found, range_err, chk_a, prime_mask, prime_cnt, last_prime});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (res_valid || busy) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_valid: got %0d active cycles expected 0", seen);
        end
        do_scan(4'd2, 4'd3, cyc);
        n_chk++;
        if (cyc !== 2 || prime_cnt !== 5'd2 || prime_mask !== 16'h000C || last_prime !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_rescan: got %0d/%0d/%h/%0d expected 2/2/000c/3",
                     cyc, prime_cnt, prime_mask, last_prime);
        end
        handshake();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        prime_tbl = 16'h28AC;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        lo        = 4'd0;
        hi        = 4'd0;
        test_reset();
        test_full_range();
        test_mid_range();
        test_single_nonprime();
        test_range_err();
        test_back_to_back();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prime_scan_ctrl.md
Name: prime_scan_ctrl

Overview:
- Sequencing controller for the 4-bit combinational prime-detect datapath.
- On a start request it sweeps an operand range [lo, hi] through the external checker, one operand per clock.
- It collects a prime bitmap, a prime count and the largest prime found, then presents the results on a valid/ready handshake.
- It sits between a host or command block and the prime checker instance; the checker itself stays purely combinational.

Parameters:
- WIDTH, 4, operand width; checker input width.
- MASK_W, 2**WIDTH, result bitmap width; one bit per operand value.
- CNT_W, WIDTH+1, prime count width; holds 0..2**WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- lo  in  WIDTH  first operand; latched on start accept.
- hi  in  WIDTH  last operand, inclusive; latched on start accept.
- busy  out  1  high in SCAN and HOLD.
- chk_a  out  WIDTH  operand driven to the prime checker.
- chk_y  in  1  checker result for chk_a, combinational in the same cycle.
- res_valid  out  1  results valid; high in HOLD.
- res_ready  in  1  consumer accepts the results.
- prime_mask  out  MASK_W  bit k set iff k is in range and k is prime.
- prime_cnt  out  CNT_W  number of primes in range.
- last_prime  out  WIDTH  largest prime in range; 0 if none.
- found  out  1  prime_cnt != 0.
- range_err  out  1  lo > hi on the accepted request.

Behaviour:
- Reset (async assert, state changes on the clock after deassert):
  - state=IDLE; chk_a, prime_mask, prime_cnt, last_prime = 0; found, range_err, busy, res_valid = 0.
- IDLE, start=1:
  - Latch lo/hi; clear mask, cnt, last_prime, found, range_err.
  - If lo<=hi: chk_a<=lo, go to SCAN.
  - Else: range_err<=1, go to HOLD directly (empty result).
- IDLE, start=0: stay in IDLE; chk_a holds its value.
- SCAN, each cycle, sample chk_y for the current chk_a:
  - If chk_y=1: set prime_mask[chk_a], prime_cnt+=1, last_prime<=chk_a, found<=1.
  - If chk_a==hi: go to HOLD, chk_a holds.
  - Else: chk_a<=chk_a+1.
  - Compare happens before increment, so hi=2**WIDTH-1 never wraps chk_a to 0.
- Latency:
  - SCAN lasts exactly hi-lo+1 cycles.
  - res_valid rises on the clock edge after the last sample.
  - Empty range: res_valid rises 1 cycle after start accept.
- HOLD:
  - res_valid=1; all result outputs stable until res_ready=1.
  - On res_ready=1: go to IDLE, res_valid drops next cycle, results keep their values until the next start accept.
- start is ignored in SCAN and HOLD, including the same cycle as the res_ready handshake; a new start is accepted earliest on the cycle after returning to IDLE.
- lo/hi changes after accept have no effect.
- chk_y is ignored outside SCAN.
- Reset mid-SCAN or mid-HOLD: immediate return to reset values; the partial result is discarded and no res_valid is produced.
- Counting is unsigned; prime_cnt cannot overflow because CNT_W covers 2**WIDTH.

Test Plan:
- lo=0, hi=15, checker attached, res_ready=1:
  - Exactly 16 SCAN cycles.
  - prime_mask=0x28AC, prime_cnt=6, last_prime=13, found=1, range_err=0.
- lo=11, hi=13:
  - 3 SCAN cycles.
  - prime_mask=0x2800, prime_cnt=2, last_prime=13.
- lo=4, hi=4:
  - 1 SCAN cycle.
  - prime_mask=0, prime_cnt=0, last_prime=0, found=0.
- lo=9, hi=3:
  - No SCAN; res_valid 1 cycle after start.
  - range_err=1, prime_cnt=0, chk_a unchanged.
- lo=12, hi=15, res_ready held low 5 cycles after res_valid, start pulsed during SCAN and HOLD:
  - Results stay stable (mask=0x2000, cnt=1, last=13).
  - Starts are ignored.
  - Return to IDLE one cycle after res_ready=1.
- Assert rst_n=0 on the 3rd SCAN cycle of lo=0, hi=15:
  - All outputs immediately at reset values.
  - No res_valid after release.
  - The next start with lo=2, hi=3 gives cnt=2, mask=0x000C.
